// File: rtl/mem_byte_ctrl_if.sv
// Word request port between the cache and mem_byte_ctrl.
// The master side issues requests; the slave side answers with busy/done/read_data.
interface mem_byte_ctrl_if;
    logic [1:0]  rw_flag;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  write_mask;
    logic [31:0] read_data;
    logic        busy;
    logic        done;

    modport master (
        output rw_flag, addr, write_data, write_mask,
        input  read_data, busy, done
    );

    modport slave (
        input  rw_flag, addr, write_data, write_mask,
        output read_data, busy, done
    );
endinterface

// File: rtl/mem_byte_ctrl.sv
// Word-to-byte memory responder: 32-bit reads and byte-masked writes, one RAM byte per cycle.
// Optional MEM_BYTE_CTRL_STAT_EN adds read/write completion counters.
module mem_byte_ctrl #(
    parameter int RAM_ADDR_BIT = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    mem_byte_ctrl_if.slave          bus,
    output logic [RAM_ADDR_BIT-1:0] o_ram_addr,
    output logic                    o_ram_re,
    output logic                    o_ram_we,
    output logic [7:0]              o_ram_wdata,
    input  logic [7:0]              i_ram_rdata
`ifdef MEM_BYTE_CTRL_STAT_EN
    ,
    output logic [31:0]             o_stat_reads,
    output logic [31:0]             o_stat_writes
`endif
);

    localparam int WW = RAM_ADDR_BIT - 2;

    typedef enum logic [1:0] {IDLE, RD, RD_LAST, WR} state_t;

    state_t                  r_state, w_state;
    logic [WW-1:0]           r_word, w_word;
    logic [31:0]             r_wdata, w_wdata;
    logic [3:0]              r_mask, w_mask;
    logic [1:0]              r_cnt, w_cnt;
    logic [23:0]             r_buf, w_buf;
    logic [31:0]             r_rdata, w_rdata;
    logic                    r_done, w_done;
    logic [RAM_ADDR_BIT-1:0] r_ram_addr, w_addr;
    logic                    r_ram_re, w_re;
    logic                    r_ram_we, w_we;
    logic [7:0]              r_ram_wdata, w_wbyte;
    logic                    w_rd_done, w_wr_done;

    logic                    w_open;
    logic                    w_accept;
    logic [3:0]              w_msrc;
    logic [31:0]             w_dsrc;
    logic [WW-1:0]           w_wsrc;
    logic [1:0]              w_idx;
    logic [3:0]              w_bit;
    logic                    w_unused_addr;

    assign w_unused_addr = ^{bus.addr[31:RAM_ADDR_BIT], bus.addr[1:0]};

    // The done cycle of a read is also open for a new request.
    assign w_open   = (r_state == IDLE) || (r_state == RD_LAST);
    assign w_accept = w_open && (bus.rw_flag != 2'b00);
    assign w_msrc   = w_open ? bus.write_mask : r_mask;
    assign w_dsrc   = w_open ? bus.write_data : r_wdata;
    assign w_wsrc   = w_open ? bus.addr[RAM_ADDR_BIT-1:2] : r_word;

    always_comb begin
        w_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_msrc[i]) w_idx = i[1:0];
        end
    end

    assign w_bit = 4'b0001 << w_idx;

    always_comb begin
        w_state   = r_state;
        w_word    = r_word;
        w_wdata   = r_wdata;
        w_mask    = r_mask;
        w_cnt     = r_cnt;
        w_buf     = r_buf;
        w_rdata   = r_rdata;
        w_done    = 1'b0;
        w_re      = 1'b0;
        w_we      = 1'b0;
        w_addr    = r_ram_addr;
        w_wbyte   = r_ram_wdata;
        w_rd_done = 1'b0;
        w_wr_done = 1'b0;
        unique case (r_state)
            RD: begin
                unique case (r_cnt)
                    2'd1:    w_buf[7:0]   = i_ram_rdata;
                    2'd2:    w_buf[15:8]  = i_ram_rdata;
                    2'd3:    w_buf[23:16] = i_ram_rdata;
                    default: ;
                endcase
                if (r_cnt == 2'd3) begin
                    w_state   = RD_LAST;
                    w_done    = 1'b1;
                    w_rd_done = 1'b1;
                end else begin
                    w_cnt  = r_cnt + 2'd1;
                    w_re   = 1'b1;
                    w_addr = {r_word, w_cnt};
                end
            end
            WR: begin
                if (r_mask == 4'd0) begin
                    w_state   = IDLE;
                    w_done    = 1'b1;
                    w_wr_done = 1'b1;
                end else begin
                    w_we    = 1'b1;
                    w_addr  = {r_word, w_idx};
                    w_wbyte = w_dsrc[{w_idx, 3'b000} +: 8];
                    w_mask  = r_mask & ~w_bit;
                end
            end
            default: begin
                if (r_state == RD_LAST) begin
                    w_rdata = {i_ram_rdata, r_buf};
                    w_state = IDLE;
                end
                if (w_accept) begin
                    w_word = w_wsrc;
                    if (bus.rw_flag[0]) begin
                        w_state = RD;
                        w_cnt   = 2'd0;
                        w_re    = 1'b1;
                        w_addr  = {w_wsrc, 2'b00};
                    end else begin
                        w_wdata = bus.write_data;
                        if (bus.write_mask == 4'd0) begin
                            w_state   = IDLE;
                            w_done    = 1'b1;
                            w_wr_done = 1'b1;
                        end else begin
                            w_state = WR;
                            w_we    = 1'b1;
                            w_addr  = {w_wsrc, w_idx};
                            w_wbyte = w_dsrc[{w_idx, 3'b000} +: 8];
                            w_mask  = bus.write_mask & ~w_bit;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_word      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_rdata     <= '0;
            r_done      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_re    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
        end else begin
            r_state     <= w_state;
            r_word      <= w_word;
            r_wdata     <= w_wdata;
            r_mask      <= w_mask;
            r_cnt       <= w_cnt;
            r_buf       <= w_buf;
            r_rdata     <= w_rdata;
            r_done      <= w_done;
            r_ram_addr  <= w_addr;
            r_ram_re    <= w_re;
            r_ram_we    <= w_we;
            r_ram_wdata <= w_wbyte;
        end
    end

    // Byte 3 arrives in the done cycle itself, so it is forwarded straight from the RAM.
    assign bus.read_data = (r_state == RD_LAST) ? {i_ram_rdata, r_buf} : r_rdata;
    assign bus.busy      = (r_state == RD) || (r_state == WR);
    assign bus.done      = r_done;

    assign o_ram_addr  = r_ram_addr;
    assign o_ram_re    = r_ram_re;
    assign o_ram_we    = r_ram_we;
    assign o_ram_wdata = r_ram_wdata;

`ifdef MEM_BYTE_CTRL_STAT_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
        end else begin
            if (w_rd_done) r_stat_reads  <= r_stat_reads + 32'd1;
            if (w_wr_done) r_stat_writes <= r_stat_writes + 32'd1;
        end
    end

    assign o_stat_reads  = r_stat_reads;
    assign o_stat_writes = r_stat_writes;
`else
    logic w_unused_stat;
    assign w_unused_stat = w_rd_done ^ w_wr_done;
`endif

endmodule

// File: tb/tb_mem_byte_ctrl.sv
// Directed scoreboard bench for mem_byte_ctrl with a 1-cycle-latency byte RAM model.
// RAM accesses and completions are checked against queues filled when requests are driven.
module tb_mem_byte_ctrl;

    logic        clk;
    logic        rst;
    logic [16:0] ram_addr;
    logic        ram_re;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
`ifdef MEM_BYTE_CTRL_STAT_EN
    logic [31:0] stat_reads;
    logic [31:0] stat_writes;
`endif

    mem_byte_ctrl_if bus();

    mem_byte_ctrl #(.RAM_ADDR_BIT(17)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_ram_addr  (ram_addr),
        .o_ram_re    (ram_re),
        .o_ram_we    (ram_we),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata)
`ifdef MEM_BYTE_CTRL_STAT_EN
        ,
        .o_stat_reads  (stat_reads),
        .o_stat_writes (stat_writes)
`endif
    );

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } done_t;

    typedef struct {
        bit          we;
        logic [16:0] addr;
        logic [7:0]  wd;
    } acc_t;

    done_t       dq[$];
    acc_t        aq[$];
    logic [7:0]  ram [0:131071];
    logic [7:0]  sh [int];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          we_cnt = 0;
    bit          sb_on = 1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_re) ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ram_we) we_cnt++;
        if (ram_re && ram_we) chk("re_we_overlap", 1, 0);
        if (bus.done) begin
            chk("done_busy", bus.busy, 0);
            if (dq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                done_t e;
                e = dq.pop_front();
                chk("done_cycle", cyc, e.cyc);
                if (e.rd) chk("read_data", bus.read_data, e.data);
            end
        end
        if (sb_on && (ram_re || ram_we)) begin
            if (aq.size() == 0) begin
                chk("unexpected_ram", 1, 0);
            end else begin
                acc_t x;
                x = aq.pop_front();
                chk("ram_access", {ram_we, ram_addr, ram_we ? ram_wdata : 8'h00},
                    {x.we, x.addr, x.wd});
            end
        end
    end

    task automatic req(input logic [1:0] rw, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
        logic [16:0] base;
        done_t e;
        acc_t x;
        int n;
        int nb;
        base = {a[16:2], 2'b00};
        n = cyc + 1;
        bus.rw_flag    = rw;
        bus.addr       = a;
        bus.write_data = d;
        bus.write_mask = m;
        if (rw[0]) begin
            for (int k = 0; k < 4; k++) begin
                x = '{1'b0, base + 17'(k), 8'h00};
                aq.push_back(x);
            end
            e = '{1'b1, {sh[base+3], sh[base+2], sh[base+1], sh[int'(base)]}, n + 4};
        end else begin
            nb = 0;
            for (int k = 0; k < 4; k++) begin
                if (m[k]) begin
                    x = '{1'b1, base + 17'(k), d[8*k +: 8]};
                    aq.push_back(x);
                    sh[base+k] = d[8*k +: 8];
                    nb++;
                end
            end
            e = '{1'b0, 32'h0, n + nb};
        end
        dq.push_back(e);
        @(posedge clk);
        #1 bus.rw_flag = 2'b00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (dq.size() == 0 && aq.size() == 0 && !bus.busy && !bus.done) break;
            @(negedge clk);
            #1;
        end
        chk("drain", dq.size() + aq.size(), 0);
    endtask

    task automatic preload(input int a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            ram[a+k] = w[8*k +: 8];
            sh[a+k]  = w[8*k +: 8];
        end
    endtask

    initial begin
        int i;
        for (int k = 0; k < 131072; k++) ram[k] = 8'h00;
        preload(32'h100, 32'h44332211);
        preload(32'h104, 32'h88776655);
        preload(32'h200, 32'h04030201);
        preload(32'h300, 32'h00000000);
        preload(32'h400, 32'h00000000);
        preload(32'h010, 32'hEFBEADDE);
        bus.rw_flag    = 2'b00;
        bus.addr       = '0;
        bus.write_data = '0;
        bus.write_mask = '0;
        rst = 1'b1;
        #3;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_rdata", bus.read_data, 0);
        chk("rst_ram", {ram_re, ram_we, ram_addr, ram_wdata}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // 1: word read with unaligned low bits
        req(2'b01, 32'h102, 32'h0, 4'h0);
        chk("rd_busy_c1", bus.busy, 1);
        wait_idle();

        // 2: sparse write then read back the merged word
        req(2'b10, 32'h200, 32'hAABBCCDD, 4'b1010);
        wait_idle();
        req(2'b01, 32'h200, 32'h0, 4'h0);
        wait_idle();

        // 3: empty mask completes in cycle 1 without going busy
        req(2'b10, 32'h104, 32'h12345678, 4'h0);
        chk("m0_busy", bus.busy, 0);
        chk("m0_done", bus.done, 1);
        wait_idle();
        req(2'b01, 32'h104, 32'h0, 4'h0);
        wait_idle();

        // read_data must hold across a write; upper address bits ignored
        req(2'b10, 32'h300, 32'hCAFEF00D, 4'hF);
        chk("hold_c1", bus.read_data, 32'h88776655);
        @(negedge clk);
        #1;
        chk("hold_c2", bus.read_data, 32'h88776655);
        wait_idle();
        req(2'b01, 32'h0002_0300, 32'h0, 4'h0);
        wait_idle();

        // 4: back-to-back read accepted in the done cycle
        req(2'b01, 32'h100, 32'h0, 4'h0);
        for (i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) break;
        end
        chk("b2b_first_done", bus.done, 1);
        req(2'b01, 32'h104, 32'h0, 4'h0);
        wait_idle();

        // 5: reset in cycle 2 of a full write aborts it
        sb_on = 1'b0;
        we_cnt = 0;
        bus.rw_flag    = 2'b10;
        bus.addr       = 32'h400;
        bus.write_data = 32'h11223344;
        bus.write_mask = 4'hF;
        @(posedge clk);
        #1 bus.rw_flag = 2'b00;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_we", ram_we, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (6) @(negedge clk);
        chk("abort_we_cnt", we_cnt, 1);
        chk("abort_ram1", ram[32'h401], 8'h00);
        rst = 1'b0;
        sb_on = 1'b1;
        sh[32'h400] = 8'h44;
        @(negedge clk);
        #1;
        chk("post_rst_rdata", bus.read_data, 0);
        req(2'b01, 32'h400, 32'h0, 4'h0);
        wait_idle();

        // 6: both flag bits set is a read
        req(2'b11, 32'h10, 32'hFFFFFFFF, 4'hF);
        wait_idle();
`ifdef MEM_BYTE_CTRL_STAT_EN
        chk("stat_reads", stat_reads, 2);
        chk("stat_writes", stat_writes, 0);
`endif
        chk("ram_untouched", ram[32'h10], 8'hDE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
